// File: rtl/display_mux.sv
// Time-multiplexed digit driver: cycles through NUM_DIGITS slots with DWELL show time
// and BLANK dead time. Digit values and enables are snapshotted at the start of each frame.
module display_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [DIGIT_W-1:0]            s,
    output logic [NUM_DIGITS-1:0]         disp,
    output logic                          frame_start
);

    // state    | meaning
    // ST_BLANK | all digits off; waiting BLANK cycles before showing slot r_idx
    // ST_SHOW  | slot r_idx driven for DWELL cycles (disp gated by its enable)

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                          r_state;
    logic [CNT_W-1:0]                r_cnt;
    logic [IDX_W-1:0]                r_idx;
    logic [NUM_DIGITS*DIGIT_W-1:0]   r_snap;
    logic [NUM_DIGITS-1:0]           r_en_snap;
    logic [DIGIT_W-1:0]              r_s;
    logic [NUM_DIGITS-1:0]           r_disp;
    logic                            r_frame_start;

    logic [IDX_W-1:0]      w_adv_idx;
    logic [IDX_W-1:0]      w_tgt_idx;
    logic                  w_tgt_first;
    logic [DIGIT_W-1:0]    w_tgt_s;
    logic [NUM_DIGITS-1:0] w_tgt_disp;
    logic                  w_blank_done;
    logic                  w_dwell_done;
    logic                  w_enter_show;

    // Slot 0 reads the live inputs so the first slot of a frame uses the fresh snapshot.
    always_comb begin
        w_adv_idx   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        w_tgt_idx   = (r_state == ST_SHOW) ? w_adv_idx : r_idx;
        w_tgt_first = (w_tgt_idx == '0);
        w_tgt_s     = '0;
        w_tgt_disp  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_tgt_idx == IDX_W'(k)) begin
                w_tgt_s       = w_tgt_first ? digits[k*DIGIT_W +: DIGIT_W]
                                            : r_snap[k*DIGIT_W +: DIGIT_W];
                w_tgt_disp[k] = w_tgt_first ? digit_en[k] : r_en_snap[k];
            end
        end
        w_blank_done = (BLANK == 0) || (r_cnt == BLANK_LAST);
        w_dwell_done = (r_cnt == DWELL_LAST);
        w_enter_show = (r_state == ST_BLANK) ? w_blank_done
                                             : (w_dwell_done && (BLANK == 0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_BLANK;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_snap        <= '0;
            r_en_snap     <= '0;
            r_s           <= '0;
            r_disp        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_enter_show) begin
                r_state       <= ST_SHOW;
                r_cnt         <= '0;
                r_idx         <= w_tgt_idx;
                r_s           <= w_tgt_s;
                r_disp        <= w_tgt_disp;
                r_frame_start <= w_tgt_first;
                if (w_tgt_first) begin
                    r_snap    <= digits;
                    r_en_snap <= digit_en;
                end
            end else if ((r_state == ST_SHOW) && w_dwell_done) begin
                r_state <= ST_BLANK;
                r_cnt   <= '0;
                r_idx   <= w_adv_idx;
                r_disp  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign s           = r_s;
    assign disp        = r_disp;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux: 4-digit instance with BLANK=2 and a 2-digit instance with BLANK=0.
module tb_display_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h4321;
    logic [3:0]  en = 4'hF;
    logic [3:0]  s;
    logic [3:0]  disp;
    logic        fs;

    logic        rst0 = 1'b1;
    logic [7:0]  digits0 = 8'h95;
    logic [1:0]  en0 = 2'b11;
    logic [3:0]  s0;
    logic [1:0]  disp0;
    logic        fs0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_mux #(.NUM_DIGITS(4), .DIGIT_W(4), .DWELL(4), .BLANK(2)) dut (
        .clk(clk), .reset(rst), .digits(digits), .digit_en(en),
        .s(s), .disp(disp), .frame_start(fs)
    );

    display_mux #(.NUM_DIGITS(2), .DIGIT_W(4), .DWELL(4), .BLANK(0)) dut0 (
        .clk(clk), .reset(rst0), .digits(digits0), .digit_en(en0),
        .s(s0), .disp(disp0), .frame_start(fs0)
    );

    always @(negedge clk) begin
        checks++;
        assert ($onehot0(disp) && $onehot0(disp0)) else begin
            errors++;
            $display("FAIL onehot0 disp=%b disp0=%b at %0t", disp, disp0, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0 (first sample point after reset release).
    task automatic restart();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [3:0] exp_disp(int n, logic [3:0] e);
        int p, slot, q;
        p = n % 24; slot = p / 6; q = p % 6;
        if (q >= 2 && e[slot]) return 4'b0001 << slot;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] exp_s(int n, logic [15:0] f0, logic [15:0] f1);
        int p, slot, q, fr;
        logic [15:0] d;
        if (n < 2) return 4'h0;
        p = n % 24; slot = p / 6; q = p % 6; fr = n / 24;
        if (q < 2) begin
            slot = slot - 1;
            if (slot < 0) begin slot = 3; fr = fr - 1; end
        end
        d = (fr == 0) ? f0 : f1;
        return 4'(d >> (4 * slot));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks += 3;
        if (disp !== 4'b0) begin errors++; $display("FAIL reset_disp got %b exp 0000", disp); end
        if (s !== 4'h0) begin errors++; $display("FAIL reset_s got %h exp 0", s); end
        if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", fs); end
    endtask

    task automatic test_sequence();
        logic [3:0] ed, es;
        logic ef;
        digits = 16'h4321; en = 4'hF;
        restart();
        for (int n = 0; n < 50; n++) begin
            ed = exp_disp(n, 4'hF);
            es = exp_s(n, 16'h4321, 16'h4321);
            ef = ((n % 24) == 2);
            checks += 3;
            if (disp !== ed) begin errors++; $display("FAIL seq_disp n=%0d got %b exp %b", n, disp, ed); end
            if (s !== es) begin errors++; $display("FAIL seq_s n=%0d got %h exp %h", n, s, es); end
            if (fs !== ef) begin errors++; $display("FAIL seq_fs n=%0d got %b exp %b", n, fs, ef); end
            tick();
        end
    endtask

    task automatic test_snapshot();
        logic [3:0] ed, es;
        digits = 16'h4321; en = 4'hF;
        restart();
        for (int n = 0; n < 50; n++) begin
            if (n == 9) digits = 16'hABCD;
            ed = exp_disp(n, 4'hF);
            es = exp_s(n, 16'h4321, 16'hABCD);
            checks += 2;
            if (disp !== ed) begin errors++; $display("FAIL snap_disp n=%0d got %b exp %b", n, disp, ed); end
            if (s !== es) begin errors++; $display("FAIL snap_s n=%0d got %h exp %h", n, s, es); end
            tick();
        end
    endtask

    task automatic test_enable(input logic [3:0] e);
        logic [3:0] ed;
        logic ef;
        digits = 16'h4321; en = e;
        restart();
        for (int n = 0; n < 50; n++) begin
            ed = exp_disp(n, e);
            ef = ((n % 24) == 2);
            checks += 2;
            if (disp !== ed) begin errors++; $display("FAIL en%b_disp n=%0d got %b exp %b", e, n, disp, ed); end
            if (fs !== ef) begin errors++; $display("FAIL en%b_fs n=%0d got %b exp %b", e, n, fs, ef); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] ed, es;
        digits = 16'h4321; en = 4'hF;
        restart();
        for (int n = 0; n < 15; n++) tick();
        checks += 2;
        if (disp !== 4'b0100) begin errors++; $display("FAIL arst_pre_disp got %b exp 0100", disp); end
        if (s !== 4'h3) begin errors++; $display("FAIL arst_pre_s got %h exp 3", s); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (disp !== 4'b0) begin errors++; $display("FAIL arst_disp got %b exp 0000", disp); end
        if (s !== 4'h0) begin errors++; $display("FAIL arst_s got %h exp 0", s); end
        if (fs !== 1'b0) begin errors++; $display("FAIL arst_fs got %b exp 0", fs); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            ed = exp_disp(n, 4'hF);
            es = exp_s(n, 16'h4321, 16'h4321);
            checks += 2;
            if (disp !== ed) begin errors++; $display("FAIL arst_seq_disp n=%0d got %b exp %b", n, disp, ed); end
            if (s !== es) begin errors++; $display("FAIL arst_seq_s n=%0d got %h exp %h", n, s, es); end
            tick();
        end
    endtask

    task automatic test_blank0();
        logic [1:0] ed;
        logic [3:0] es;
        logic ef;
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        for (int n = 0; n < 25; n++) begin
            if (n == 0) begin
                ed = 2'b00; es = 4'h0; ef = 1'b0;
            end else if (((n - 1) / 4) % 2 == 0) begin
                ed = 2'b01; es = 4'h5; ef = ((n - 1) % 8 == 0);
            end else begin
                ed = 2'b10; es = 4'h9; ef = 1'b0;
            end
            checks += 3;
            if (disp0 !== ed) begin errors++; $display("FAIL b0_disp n=%0d got %b exp %b", n, disp0, ed); end
            if (s0 !== es) begin errors++; $display("FAIL b0_s n=%0d got %h exp %h", n, s0, es); end
            if (fs0 !== ef) begin errors++; $display("FAIL b0_fs n=%0d got %b exp %b", n, fs0, ef); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_snapshot();
        test_enable(4'b1010);
        test_enable(4'b0000);
        test_async_reset();
        test_blank0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
